// File: rtl/rd53_bgpv_fe_ctrl.sv
// rd53_bgpv_fe_ctrl -- front-end injection / discriminator readout controller.
// Drives the two-phase charge injection (S0, then S1) and holds the analog
// configuration (GAIN_SEL, POWER_DOWN, TH_DAC). After injection it watches the
// synchronized discriminator for a hit and returns the result on a
// valid/ready handshake.
// Build option: define RD53_BGPV_TOT_EN to add the MEAS state, which measures
// time-over-threshold. Without it, a hit ends the measurement at once and
// res_tot / res_ovf are tied to zero.
module rd53_bgpv_fe_ctrl #(
   parameter int INJ_WIDTH = 4,
   parameter int TIMEOUT   = 63,
   parameter int TOT_W     = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             cfg_we,
   input  logic             cfg_gain_sel,
   input  logic             cfg_power_down,
   input  logic [3:0]       cfg_th_dac,
   input  logic             inj_valid,
   output logic             inj_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_hit,
   output logic [TOT_W-1:0] res_tot,
   output logic             res_ovf,
   output logic             S0,
   output logic             S1,
   output logic             GAIN_SEL,
   output logic             POWER_DOWN,
   output logic [3:0]       TH_DAC,
   input  logic             HIT
);

   // One counter serves the injection phases and the WAIT/MEAS timeouts,
   // so it is sized for whichever limit is larger.
   localparam int CMAX = (TIMEOUT > INJ_WIDTH) ? TIMEOUT : INJ_WIDTH;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] INJ_LAST = CW'(INJ_WIDTH - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

`ifdef RD53_BGPV_TOT_EN
   typedef enum logic [2:0] {IDLE, INJ0, INJ1, WAIT, MEAS, DONE} state_t;
   logic [TOT_W-1:0] tot_q;
   logic             ovf_q;
`else
   typedef enum logic [2:0] {IDLE, INJ0, INJ1, WAIT, DONE} state_t;
`endif

   state_t        state;
   logic [CW-1:0] cnt;
   logic          hs_m, hs, hs_d;
   logic          rise;

   assign inj_ready = (state == IDLE) & ~POWER_DOWN;
   assign rise      = hs & ~hs_d;

`ifdef RD53_BGPV_TOT_EN
   assign res_tot = tot_q;
   assign res_ovf = ovf_q;
`else
   assign res_tot = '0;
   assign res_ovf = 1'b0;
`endif

   // Two-flop synchronizer for the asynchronous discriminator, plus a delayed
   // copy so that only a rising edge can be treated as a hit.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hs_m <= 1'b0;
         hs   <= 1'b0;
         hs_d <= 1'b0;
      end else begin
         hs_m <= HIT;
         hs   <= hs_m;
         hs_d <= hs;
      end
   end

   // Control FSM. All outputs are registered here.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         cnt        <= '0;
         S0         <= 1'b0;
         S1         <= 1'b0;
         GAIN_SEL   <= 1'b0;
         POWER_DOWN <= 1'b1;
         TH_DAC     <= 4'd8;
         res_valid  <= 1'b0;
         res_hit    <= 1'b0;
`ifdef RD53_BGPV_TOT_EN
         tot_q      <= '0;
         ovf_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // Configuration is accepted only while idle. A write in the same
               // cycle as an accepted injection still takes effect.
               if (cfg_we) begin
                  GAIN_SEL   <= cfg_gain_sel;
                  POWER_DOWN <= cfg_power_down;
                  TH_DAC     <= cfg_th_dac;
               end
               if (inj_valid && inj_ready) begin
                  state   <= INJ0;
                  S0      <= 1'b1;
                  cnt     <= '0;
                  res_hit <= 1'b0;
`ifdef RD53_BGPV_TOT_EN
                  tot_q   <= '0;
                  ovf_q   <= 1'b0;
`endif
               end
            end
            INJ0: begin
               if (cnt == INJ_LAST) begin
                  state <= INJ1;
                  S0    <= 1'b0;
                  S1    <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            INJ1: begin
               if (cnt == INJ_LAST) begin
                  state <= WAIT;
                  S1    <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT: begin
               // A level that was already high on entry has no rising edge,
               // so it cannot count as a hit.
               if (rise) begin
`ifdef RD53_BGPV_TOT_EN
                  state <= MEAS;
                  tot_q <= TOT_W'(1);
                  cnt   <= '0;
`else
                  state     <= DONE;
                  res_valid <= 1'b1;
                  res_hit   <= 1'b1;
`endif
               end else if (cnt == TO_LAST) begin
                  state     <= DONE;
                  res_valid <= 1'b1;
                  res_hit   <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef RD53_BGPV_TOT_EN
            MEAS: begin
               if (!hs) begin
                  state     <= DONE;
                  res_valid <= 1'b1;
                  res_hit   <= 1'b1;
               end else begin
                  // Saturate instead of wrapping when the pulse is long.
                  if (tot_q != '1) tot_q <= tot_q + 1'b1;
                  if (cnt == TO_LAST) begin
                     state     <= DONE;
                     res_valid <= 1'b1;
                     res_hit   <= 1'b1;
                     ovf_q     <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
`endif
            DONE: begin
               // The result fields are held until the consumer takes them.
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rd53_bgpv_fe_ctrl.sv
// Directed bench for rd53_bgpv_fe_ctrl (INJ_WIDTH=4, TIMEOUT=63, TOT_W=4).
// Expected ToT/overflow values depend on whether RD53_BGPV_TOT_EN is defined.
module tb_rd53_bgpv_fe_ctrl;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       cfg_we = 1'b0, cfg_gain_sel = 1'b0, cfg_power_down = 1'b0;
   logic [3:0] cfg_th_dac = 4'd0;
   logic       inj_valid = 1'b0, inj_ready;
   logic       res_valid, res_ready = 1'b0;
   logic       res_hit, res_ovf;
   logic [3:0] res_tot;
   logic       S0, S1, GAIN_SEL, POWER_DOWN;
   logic [3:0] TH_DAC;
   logic       HIT = 1'b0;

   int passes = 0;
   int total  = 0;

   rd53_bgpv_fe_ctrl #(.INJ_WIDTH(4), .TIMEOUT(63), .TOT_W(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .cfg_we(cfg_we), .cfg_gain_sel(cfg_gain_sel), .cfg_power_down(cfg_power_down),
      .cfg_th_dac(cfg_th_dac),
      .inj_valid(inj_valid), .inj_ready(inj_ready),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_hit(res_hit), .res_tot(res_tot), .res_ovf(res_ovf),
      .S0(S0), .S1(S1), .GAIN_SEL(GAIN_SEL), .POWER_DOWN(POWER_DOWN), .TH_DAC(TH_DAC),
      .HIT(HIT)
   );

   always #5 CLK = ~CLK;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit
   // after the rising edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Wait (bounded) for res_valid; returns the number of clocks waited.
   task automatic wait_valid(input string tag, output int n);
      n = 0;
      while (res_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (res_valid !== 1'b1) check({tag, "_timeout"}, 32'(res_valid), 32'd1);
   endtask

   // Pulse inj_valid for one accepted cycle, then run through INJ0/INJ1 so the
   // DUT is in its first WAIT cycle on return.
   task automatic inject();
      inj_valid = 1'b1;
      tick();
      inj_valid = 1'b0;
      tick(8);
   endtask

   task automatic take_result();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin : main
      int n, s0c, s1c, stable;
      logic [3:0] tot_exp6, tot_exp20, tot_exp_ovf;
      logic       ovf_exp;
`ifdef RD53_BGPV_TOT_EN
      tot_exp6 = 4'd6; tot_exp20 = 4'd15; tot_exp_ovf = 4'd15; ovf_exp = 1'b1;
`else
      tot_exp6 = 4'd0; tot_exp20 = 4'd0;  tot_exp_ovf = 4'd0;  ovf_exp = 1'b0;
`endif

      // Reset state
      RESET = 1'b1;
      tick(2);
      check("rst_pd",     32'(POWER_DOWN), 32'd1);
      check("rst_th",     32'(TH_DAC),     32'd8);
      check("rst_gain",   32'(GAIN_SEL),   32'd0);
      check("rst_s0s1",   32'({S0, S1}),   32'd0);
      check("rst_ready",  32'(inj_ready),  32'd0);
      check("rst_valid",  32'(res_valid),  32'd0);
      check("rst_tot",    32'(res_tot),    32'd0);
      RESET = 1'b0;

      // Powered down: an injection request is refused
      inj_valid = 1'b1;
      tick();
      inj_valid = 1'b0;
      check("pd_no_inj",  32'(S0),         32'd0);

      // Configuration write in IDLE
      cfg_we = 1'b1; cfg_gain_sel = 1'b1; cfg_power_down = 1'b0; cfg_th_dac = 4'd5;
      tick();
      cfg_we = 1'b0;
      check("cfg_gain",   32'(GAIN_SEL),   32'd1);
      check("cfg_pd",     32'(POWER_DOWN), 32'd0);
      check("cfg_th",     32'(TH_DAC),     32'd5);
      check("cfg_ready",  32'(inj_ready),  32'd1);

      // Injection phases, plus a configuration write dropped during WAIT
      inj_valid = 1'b1;
      tick();
      inj_valid = 1'b0;
      s0c = 0; s1c = 0;
      for (int i = 0; i < 8; i++) begin
         s0c += int'(S0);
         s1c += int'(S1);
         tick();
      end
      check("s0_width",   32'(s0c),        32'd4);
      check("s1_width",   32'(s1c),        32'd4);
      check("wait_s0s1",  32'({S0, S1}),   32'd0);
      cfg_we = 1'b1; cfg_gain_sel = 1'b0; cfg_power_down = 1'b1; cfg_th_dac = 4'd3;
      tick();
      cfg_we = 1'b0;
      check("wait_cfg_gain", 32'(GAIN_SEL),   32'd1);
      check("wait_cfg_pd",   32'(POWER_DOWN), 32'd0);
      check("wait_cfg_th",   32'(TH_DAC),     32'd5);
      tick(8);
      HIT = 1'b1;
      tick(6);
      HIT = 1'b0;
      wait_valid("hit6", n);
      check("hit6_hit",   32'(res_hit),    32'd1);
      check("hit6_tot",   32'(res_tot),    32'(tot_exp6));
      check("hit6_ovf",   32'(res_ovf),    32'd0);

      // Consumer stalls for 5 cycles: result must hold
      stable = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (res_valid !== 1'b1 || res_hit !== 1'b1 || res_tot !== tot_exp6 ||
             res_ovf !== 1'b0 || inj_ready !== 1'b0) stable = 0;
      end
      check("stall_stable", 32'(stable),   32'd1);
      take_result();
      check("ack_valid",  32'(res_valid),  32'd0);
      check("ack_ready",  32'(inj_ready),  32'd1);

      // HIT held high from before WAIT: no edge, WAIT times out
      HIT = 1'b1;
      inject();
      wait_valid("to", n);
      check("to_cycles",  32'(n),          32'd63);
      check("to_hit",     32'(res_hit),    32'd0);
      check("to_tot",     32'(res_tot),    32'd0);
      check("to_ovf",     32'(res_ovf),    32'd0);
      HIT = 1'b0;
      take_result();

      // 20-cycle pulse saturates the ToT counter without overflow
      inject();
      tick(3);
      HIT = 1'b1;
      tick(20);
      HIT = 1'b0;
      wait_valid("hit20", n);
      check("hit20_hit",  32'(res_hit),    32'd1);
      check("hit20_tot",  32'(res_tot),    32'(tot_exp20));
      check("hit20_ovf",  32'(res_ovf),    32'd0);
      take_result();

      // Stuck-high discriminator: measurement times out with overflow
      inject();
      tick(3);
      HIT = 1'b1;
      tick(100);
      wait_valid("stuck", n);
      check("stuck_hit",  32'(res_hit),    32'd1);
      check("stuck_tot",  32'(res_tot),    32'(tot_exp_ovf));
      check("stuck_ovf",  32'(res_ovf),    32'(ovf_exp));
      HIT = 1'b0;
      take_result();

      // Reset in the middle of a measurement
      inject();
      tick(2);
      HIT = 1'b1;
      tick(6);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      HIT = 1'b0;
      check("mrst_valid", 32'(res_valid),  32'd0);
      check("mrst_ready", 32'(inj_ready),  32'd0);
      check("mrst_pd",    32'(POWER_DOWN), 32'd1);
      check("mrst_th",    32'(TH_DAC),     32'd8);

      // Reset in the middle of an injection phase
      cfg_we = 1'b1; cfg_gain_sel = 1'b0; cfg_power_down = 1'b0; cfg_th_dac = 4'd8;
      tick();
      cfg_we = 1'b0;
      inj_valid = 1'b1;
      tick();
      inj_valid = 1'b0;
      tick(2);
      check("irst_pre_s0", 32'(S0),        32'd1);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("irst_s0s1",  32'({S0, S1}),   32'd0);
      check("irst_valid", 32'(res_valid),  32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
